// File: rtl/buffer_fill_rx_pkg.sv
// Shared constants, slot layout, destination encoding and rx FSM states for the
// packet buffer writer.
package buffer_fill_rx_pkg;

    localparam int DEPTH     = 6;
    localparam int SLOT_W    = 3;
    localparam int DROP_W    = 8;
    localparam int OCC_W     = 3;
    localparam int NBUF      = 4;
    localparam int VALID_BIT = 0;
    localparam int TAG_LSB   = 1;

    typedef enum logic [1:0] {
        DEST_B1 = 2'b00,
        DEST_B2 = 2'b01,
        DEST_B3 = 2'b10,
        DEST_B4 = 2'b11
    } dest_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_D1   = 3'd1,
        ST_D0   = 3'd2,
        ST_T1   = 3'd3,
        ST_T0   = 3'd4
    } rx_state_e;

    function automatic logic [SLOT_W-1:0] make_slot(input logic [1:0] tag);
        logic [SLOT_W-1:0] slot;
        slot                  = '0;
        slot[VALID_BIT]       = 1'b1;
        slot[TAG_LSB +: 2]    = tag;
        return slot;
    endfunction

endpackage

// File: rtl/buffer_fill_rx_slot_queue.sv
// One packet buffer with its occupancy counter. Dequeue shifts toward slot 0; an
// enqueue lands just above the last occupied slot after any dequeue in that cycle.
module buffer_fill_rx_slot_queue
    import buffer_fill_rx_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_enq,
    input  logic [SLOT_W-1:0]       i_enq_slot,
    input  logic                    i_deq,
    output logic [DEPTH*SLOT_W-1:0] o_data,
    output logic [OCC_W-1:0]        o_occ,
    output logic                    o_full,
    output logic                    o_drop
);

    logic [DEPTH*SLOT_W-1:0] r_data;
    logic [OCC_W-1:0]        r_occ;
    logic                    r_full;

    logic                    w_do_deq;
    logic [DEPTH*SLOT_W-1:0] w_shifted;
    logic [OCC_W-1:0]        w_occ_mid;
    logic                    w_accept;
    logic [OCC_W-1:0]        w_occ_next;
    logic [DEPTH*SLOT_W-1:0] w_data_next;

    assign w_do_deq   = i_deq && (r_occ != '0);
    assign w_shifted  = w_do_deq ? {SLOT_W'(0), r_data[DEPTH*SLOT_W-1:SLOT_W]} : r_data;
    assign w_occ_mid  = r_occ - OCC_W'(w_do_deq);
    // Space is judged after the same-cycle dequeue, so a full buffer being drained still accepts.
    assign w_accept   = i_enq && (w_occ_mid != OCC_W'(DEPTH));
    assign w_occ_next = w_occ_mid + OCC_W'(w_accept);

    always_comb begin
        w_data_next = w_shifted;
        for (int j = 0; j < DEPTH; j++) begin
            if (w_accept && (w_occ_mid == OCC_W'(j))) begin
                w_data_next[j*SLOT_W +: SLOT_W] = i_enq_slot;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_occ  <= '0;
            r_full <= 1'b0;
        end else begin
            r_data <= w_data_next;
            r_occ  <= w_occ_next;
            r_full <= (w_occ_next == OCC_W'(DEPTH));
        end
    end

    assign o_data = r_data;
    assign o_occ  = r_occ;
    assign o_full = r_full;
    assign o_drop = i_enq && !w_accept;

endmodule

// File: rtl/buffer_fill_rx.sv
// Serial packet receiver: deframes {start, dest[1:0], tag[1:0]} and appends the
// packet to one of four buffers; counts packets lost to full buffers.
module buffer_fill_rx
    import buffer_fill_rx_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx_bit,
    input  logic [3:0]              deq,
    output logic [DEPTH*SLOT_W-1:0] buffer1_o,
    output logic [DEPTH*SLOT_W-1:0] buffer2_o,
    output logic [DEPTH*SLOT_W-1:0] buffer3_o,
    output logic [DEPTH*SLOT_W-1:0] buffer4_o,
    output logic [4*OCC_W-1:0]      occ,
    output logic [3:0]              full,
    output logic [DROP_W-1:0]       drop_cnt,
    output logic                    busy
);

    rx_state_e          r_state;
    dest_e              r_dest;
    logic               r_tag1;
    logic               r_busy;
    logic [DROP_W-1:0]  r_drop_cnt;

    logic                    w_commit;
    logic [SLOT_W-1:0]       w_slot;
    logic [NBUF-1:0]         w_enq;
    logic [NBUF-1:0]         w_drop;
    logic [NBUF-1:0]         w_full;
    logic [DEPTH*SLOT_W-1:0] w_buf [NBUF];
    logic [OCC_W-1:0]        w_occ [NBUF];

    // The commit is combinational on the T0 cycle so the buffer updates on the tag[0] edge.
    assign w_commit = (r_state == ST_T0);
    assign w_slot   = make_slot({r_tag1, rx_bit});

    for (genvar k = 0; k < NBUF; k++) begin : g_q
        assign w_enq[k] = w_commit && (r_dest == dest_e'(k));

        buffer_fill_rx_slot_queue u_q (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_enq      (w_enq[k]),
            .i_enq_slot (w_slot),
            .i_deq      (deq[k]),
            .o_data     (w_buf[k]),
            .o_occ      (w_occ[k]),
            .o_full     (w_full[k]),
            .o_drop     (w_drop[k])
        );

        assign occ[k*OCC_W +: OCC_W] = w_occ[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_dest  <= DEST_B1;
            r_tag1  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (rx_bit) begin
                        r_state <= ST_D1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_D1: begin
                    r_dest[1] <= rx_bit;
                    r_state   <= ST_D0;
                end
                ST_D0: begin
                    r_dest[0] <= rx_bit;
                    r_state   <= ST_T1;
                end
                ST_T1: begin
                    r_tag1  <= rx_bit;
                    r_state <= ST_T0;
                end
                ST_T0: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if ((|w_drop) && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + DROP_W'(1);
        end
    end

    assign buffer1_o = w_buf[0];
    assign buffer2_o = w_buf[1];
    assign buffer3_o = w_buf[2];
    assign buffer4_o = w_buf[3];
    assign full      = w_full;
    assign drop_cnt  = r_drop_cnt;
    assign busy      = r_busy;

endmodule

// File: tb/tb_buffer_fill_rx.sv
// Directed bench for buffer_fill_rx: stimulus pushes hand-computed expectations tagged
// with the cycle they apply to; a negedge monitor pops and compares them.
module tb_buffer_fill_rx;
    import buffer_fill_rx_pkg::*;

    localparam int K_BUF  = 0;
    localparam int K_OCC  = 1;
    localparam int K_FULL = 2;
    localparam int K_DROP = 3;
    localparam int K_BUSY = 4;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    rx_bit = 1'b0;
    logic [3:0]              deq = 4'b0000;
    logic [DEPTH*SLOT_W-1:0] buffer1_o, buffer2_o, buffer3_o, buffer4_o;
    logic [4*OCC_W-1:0]      occ;
    logic [3:0]              full;
    logic [DROP_W-1:0]       drop_cnt;
    logic                    busy;

    buffer_fill_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_bit    (rx_bit),
        .deq       (deq),
        .buffer1_o (buffer1_o),
        .buffer2_o (buffer2_o),
        .buffer3_o (buffer3_o),
        .buffer4_o (buffer4_o),
        .occ       (occ),
        .full      (full),
        .drop_cnt  (drop_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          kind;
        int          idx;
        logic [17:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [17:0] get_act(input int kind, input int idx);
        logic [17:0] v;
        v = '0;
        case (kind)
            K_BUF: begin
                case (idx)
                    0:       v = buffer1_o;
                    1:       v = buffer2_o;
                    2:       v = buffer3_o;
                    default: v = buffer4_o;
                endcase
            end
            K_OCC:   v = {15'b0, occ[idx*3 +: 3]};
            K_FULL:  v = {14'b0, full};
            K_DROP:  v = {10'b0, drop_cnt};
            default: v = {17'b0, busy};
        endcase
        return v;
    endfunction

    function automatic string kind_name(input int kind);
        case (kind)
            K_BUF:   return "buffer";
            K_OCC:   return "occ";
            K_FULL:  return "full";
            K_DROP:  return "drop_cnt";
            default: return "busy";
        endcase
    endfunction

    // Monitor: compares every expectation that has come due at this negedge.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t        e;
            logic [17:0] act;
            e   = exp_q.pop_front();
            act = get_act(e.kind, e.idx);
            n_total++;
            if (act === e.val) begin
                n_pass++;
            end else begin
                $display("FAIL %s[%0d] cycle %0d: got %h, expected %h",
                         kind_name(e.kind), e.idx, cyc, act, e.val);
            end
        end
    end

    task automatic push(input int kind, input int idx, input logic [17:0] val, input int due_off);
        exp_t e;
        e.due  = cyc + due_off;
        e.kind = kind;
        e.idx  = idx;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic exp_buf(input int k, input logic [17:0] v);  push(K_BUF, k, v, 1);  endtask
    task automatic exp_occ(input int k, input logic [2:0] v);   push(K_OCC, k, {15'b0, v}, 1); endtask
    task automatic exp_full(input logic [3:0] v);               push(K_FULL, 0, {14'b0, v}, 1); endtask
    task automatic exp_drop(input logic [7:0] v);               push(K_DROP, 0, {10'b0, v}, 1); endtask
    task automatic exp_busy(input logic v);                     push(K_BUSY, 0, {17'b0, v}, 1); endtask

    task automatic step(input logic b, input logic [3:0] d);
        @(negedge clk);
        rx_bit = b;
        deq    = d;
    endtask

    task automatic send_frame(input logic [1:0] dest, input logic [1:0] tag, input logic [3:0] dq);
        step(1'b1, 4'b0000);
        exp_busy(1'b1);
        step(dest[1], 4'b0000);
        step(dest[0], 4'b0000);
        step(tag[1], 4'b0000);
        step(tag[0], dq);
        exp_busy(1'b0);
    endtask

    initial begin
        // Power-on reset
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            exp_buf(k, 18'h0);
            exp_occ(k, 3'd0);
        end
        exp_full(4'b0000);
        exp_drop(8'd0);
        exp_busy(1'b0);
        step(1'b0, 4'b0000);
        exp_busy(1'b0);

        // Stream 1,0,1,1,0 -> buffer2 slot0 = 101
        send_frame(2'b01, 2'b10, 4'b0000);
        exp_buf(1, 18'h00005);
        exp_occ(1, 3'd1);
        exp_occ(0, 3'd0);
        exp_buf(0, 18'h0);
        exp_buf(2, 18'h0);
        exp_buf(3, 18'h0);

        // Reset in the middle of a frame clears everything before the next edge
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0000);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        push(K_BUF, 1, 18'h0, 0);
        push(K_OCC, 1, 18'h0, 0);
        push(K_FULL, 0, 18'h0, 0);
        push(K_DROP, 0, 18'h0, 0);
        push(K_BUSY, 0, 18'h0, 0);
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0000);
        rst_n = 1'b1;

        // Aborted packet never written: next frame lands in slot 0
        send_frame(2'b00, 2'b11, 4'b0000);
        exp_buf(0, 18'h00007);
        exp_occ(0, 3'd1);

        // Build occ=3 in buffer1, then enqueue with a same-cycle dequeue
        send_frame(2'b00, 2'b00, 4'b0000);
        send_frame(2'b00, 2'b01, 4'b0000);
        exp_buf(0, 18'h000CF);
        exp_occ(0, 3'd3);
        send_frame(2'b00, 2'b10, 4'b0001);
        exp_buf(0, 18'h00159);
        exp_occ(0, 3'd3);

        // Drain buffer1, then one extra dequeue on empty
        repeat (3) step(1'b0, 4'b0001);
        exp_buf(0, 18'h0);
        exp_occ(0, 3'd0);
        step(1'b0, 4'b0001);
        exp_buf(0, 18'h0);
        exp_occ(0, 3'd0);

        // Occupancies {0,1,2,6}
        send_frame(2'b01, 2'b01, 4'b0000);
        exp_buf(1, 18'h00003);
        send_frame(2'b10, 2'b10, 4'b0000);
        send_frame(2'b10, 2'b11, 4'b0000);
        exp_buf(2, 18'h0003D);
        send_frame(2'b11, 2'b00, 4'b0000);
        send_frame(2'b11, 2'b01, 4'b0000);
        send_frame(2'b11, 2'b10, 4'b0000);
        send_frame(2'b11, 2'b11, 4'b0000);
        send_frame(2'b11, 2'b00, 4'b0000);
        exp_full(4'b0000);
        send_frame(2'b11, 2'b01, 4'b0000);
        exp_buf(3, 18'h19F59);
        exp_occ(3, 3'd6);
        exp_full(4'b1000);

        // Seventh frame to a full buffer is dropped
        send_frame(2'b11, 2'b11, 4'b0000);
        exp_buf(3, 18'h19F59);
        exp_occ(3, 3'd6);
        exp_drop(8'd1);
        exp_full(4'b1000);

        // Dequeue all four at once
        step(1'b0, 4'b1111);
        exp_buf(0, 18'h0);
        exp_buf(1, 18'h0);
        exp_buf(2, 18'h00007);
        exp_buf(3, 18'h033EB);
        exp_occ(0, 3'd0);
        exp_occ(1, 3'd0);
        exp_occ(2, 3'd1);
        exp_occ(3, 3'd5);
        exp_full(4'b0000);

        // Enqueue plus dequeue on an empty buffer
        send_frame(2'b00, 2'b01, 4'b0001);
        exp_buf(0, 18'h00003);
        exp_occ(0, 3'd1);

        // Refill buffer4, then a full buffer being dequeued accepts the packet
        send_frame(2'b11, 2'b00, 4'b0000);
        exp_buf(3, 18'h0B3EB);
        exp_full(4'b1000);
        send_frame(2'b11, 2'b10, 4'b1000);
        exp_buf(3, 18'h2967D);
        exp_occ(3, 3'd6);
        exp_drop(8'd1);
        exp_full(4'b1000);

        // Back-to-back drops until the counter saturates
        for (int i = 0; i < 256; i++) begin
            send_frame(2'b11, 2'b10, 4'b0000);
            if (i == 0) exp_drop(8'd2);
        end
        exp_drop(8'd255);
        exp_buf(3, 18'h2967D);

        repeat (3) begin
            step(1'b0, 4'b0000);
            exp_busy(1'b0);
            exp_drop(8'd255);
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            $display("FAIL pending_expectations: %0d left, expected 0", exp_q.size());
            n_total += exp_q.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
